// File: rtl/seq_shifter_if.sv
// Start/done handshake bundle for the iterative shifter.
// master: drives start/Rs/Imm/mode; slave: drives Rd/busy/done.
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] Rs;
    logic [CNT_W-1:0] Imm;
    logic [1:0]       mode;
    logic [WIDTH-1:0] Rd;
    logic             busy;
    logic             done;

    modport master (
        output start, Rs, Imm, mode,
        input  Rd, busy, done
    );

    modport slave (
        input  start, Rs, Imm, mode,
        output Rd, busy, done
    );
endinterface

// File: rtl/seq_shifter.sv
// Iterative shifter, one bit position per clock (SLL/SRA/ROR/ROL).
// Ports: clk, rst (sync, active-high), bus (slave: start/Rs/Imm/mode in; Rd/busy/done out).
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic          clk,
    input logic          rst,
    seq_shifter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRA = 2'b01;
    localparam logic [1:0] M_ROR = 2'b10;

    state_t           state, state_n;
    logic [WIDTH-1:0] work, stepped, rd_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       md;
    logic             accept;

    // start is only looked at when no operation is in flight
    assign accept = (state != S_SHIFT) && bus.start;

    always_comb begin
        stepped = work;
        case (md)
            M_SLL:   stepped = {work[WIDTH-2:0], 1'b0};
            M_SRA:   stepped = {work[WIDTH-1], work[WIDTH-1:1]};
            M_ROR:   stepped = {work[0], work[WIDTH-1:1]};
            default: stepped = {work[WIDTH-2:0], work[WIDTH-1]};
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_n = (bus.Imm == '0) ? S_DONE : S_SHIFT;
                else
                    state_n = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt == CNT_W'(1))
                    state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            work  <= '0;
            cnt   <= '0;
            md    <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                work <= bus.Rs;
                cnt  <= bus.Imm;
                md   <= bus.mode;
                // zero-length shift completes on the accepting edge
                if (bus.Imm == '0)
                    rd_q <= bus.Rs;
            end else if (state == S_SHIFT) begin
                work <= stepped;
                cnt  <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1))
                    rd_q <= stepped;
            end
        end
    end

    assign bus.Rd   = rd_q;
    assign bus.busy = (state == S_SHIFT);
    assign bus.done = (state == S_DONE);
endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed corners plus random ops
// compared against an arithmetic reference model.
module tb_seq_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    seq_shifter_if #(.WIDTH(16), .CNT_W(4)) bus ();

    seq_shifter #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && bus.done) done_seen++;

    function automatic logic [15:0] ref_shift(input logic [15:0] rs,
                                              input int k,
                                              input logic [1:0] m);
        logic [31:0] w;
        w = {16'h0, rs};
        case (m)
            2'b00: return 16'(w << k);
            2'b01: return 16'($signed(rs) >>> k);
            2'b10: return 16'((w >> k) | (w << (16 - k)));
            default: return 16'((w << k) | (w >> (16 - k)));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, then wait (bounded) for done; return in the done cycle.
    task automatic do_op(input logic [15:0] rs, input logic [3:0] imm,
                         input logic [1:0] m, output int bcnt,
                         output logic got, output logic [15:0] rd,
                         output logic b0);
        bus.start = 1'b1;
        bus.Rs    = rs;
        bus.Imm   = imm;
        bus.mode  = m;
        tick();
        bus.start = 1'b0;
        bus.Rs    = 16'($urandom);
        bus.Imm   = 4'($urandom);
        bus.mode  = 2'($urandom);
        bcnt = 0;
        got  = 1'b0;
        rd   = 16'hxxxx;
        b0   = bus.busy;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                got = 1'b1;
                rd  = bus.Rd;
                break;
            end
            if (bus.busy) bcnt++;
            tick();
        end
    endtask

    task automatic check_op(input string nm, input logic [15:0] rs,
                            input logic [3:0] imm, input logic [1:0] m);
        int          bc;
        logic        g, b0;
        logic [15:0] rd, exp;
        exp = ref_shift(rs, int'(imm), m);
        do_op(rs, imm, m, bc, g, rd, b0);
        checks++;
        if (!g || rd !== exp || bc != int'(imm)) begin
            errors++;
            $display("FAIL %s: done=%0b Rd=%h busy_cycles=%0d, required Rd=%h busy_cycles=%0d",
                     nm, g, rd, bc, exp, imm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.Rs = 16'hFFFF;
        bus.Imm = 4'h3;
        bus.mode = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.Rd !== 16'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: Rd=%h busy=%b done=%b, required 0000/0/0",
                     bus.Rd, bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        int          bc;
        logic        g, b0;
        logic [15:0] rd;
        check_op("sll_1_4", 16'h0001, 4'd4, 2'b00);
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Rd !== 16'h0010) begin
            errors++;
            $display("FAIL sll_idle: done=%b busy=%b Rd=%h, required 0/0/0010",
                     bus.done, bus.busy, bus.Rd);
        end
        check_op("sra_8000_15", 16'h8000, 4'd15, 2'b01);
        checks++;
        if (bus.Rd !== 16'hFFFF) begin
            errors++;
            $display("FAIL sra_ffff: Rd=%h required ffff", bus.Rd);
        end
        tick();
        check_op("sra_4000_2", 16'h4000, 4'd2, 2'b01);
        tick();
        check_op("ror_1234_4", 16'h1234, 4'd4, 2'b10);
        checks++;
        if (bus.Rd !== 16'h4123) begin
            errors++;
            $display("FAIL ror_const: Rd=%h required 4123", bus.Rd);
        end
        tick();
        check_op("rol_1234_4", 16'h1234, 4'd4, 2'b11);
        checks++;
        if (bus.Rd !== 16'h2341) begin
            errors++;
            $display("FAIL rol_const: Rd=%h required 2341", bus.Rd);
        end
        tick();
        do_op(16'hBEEF, 4'd0, 2'b10, bc, g, rd, b0);
        checks++;
        if (!g || b0 !== 1'b0 || bc != 0 || rd !== 16'hBEEF) begin
            errors++;
            $display("FAIL imm0: done=%b busy0=%b busy_cycles=%0d Rd=%h, required 1/0/0/beef",
                     g, b0, bc, rd);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.Rs = 16'($urandom);
            tick();
        end
        checks++;
        if (bus.Rd !== 16'hBEEF || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL hold: Rd=%h done=%b, required beef/0", bus.Rd, bus.done);
        end
    endtask

    task automatic test_start_mid_shift();
        bus.start = 1'b1;
        bus.Rs    = 16'h00F0;
        bus.Imm   = 4'd8;
        bus.mode  = 2'b00;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.Rs    = 16'hFFFF;
        bus.Imm   = 4'd1;
        bus.mode  = 2'b11;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30 && !bus.done; i++) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.Rd !== 16'hF000) begin
            errors++;
            $display("FAIL mid_start: done=%b Rd=%h, required 1/f000", bus.done, bus.Rd);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int          bc;
        logic        g, b0;
        logic [15:0] rd;
        check_op("b2b_first", 16'h0003, 4'd2, 2'b00);
        do_op(16'h0101, 4'd0, 2'b11, bc, g, rd, b0);
        checks++;
        if (!g || bc != 0 || rd !== 16'h0101) begin
            errors++;
            $display("FAIL b2b_imm0: done=%b busy_cycles=%0d Rd=%h, required 1/0/0101",
                     g, bc, rd);
        end
        do_op(16'h0008, 4'd3, 2'b10, bc, g, rd, b0);
        checks++;
        if (!g || b0 !== 1'b1 || bc != 3 || rd !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_shift: done=%b busy0=%b busy_cycles=%0d Rd=%h, required 1/1/3/0001",
                     g, b0, bc, rd);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        bus.start = 1'b1;
        bus.Rs    = 16'h1357;
        bus.Imm   = 4'd10;
        bus.mode  = 2'b10;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.Rd !== 16'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: Rd=%h busy=%b done=%b, required 0000/0/0",
                     bus.Rd, bus.busy, bus.done);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.Rd !== 16'h0) begin
            errors++;
            $display("FAIL rst_quiet: activity=%b Rd=%h, required 0/0000", seen, bus.Rd);
        end
    endtask

    task automatic test_random();
        int nops;
        nops = 200;
        bus.start = 1'b0;
        tick();
        tick();
        done_seen = 0;
        for (int n = 0; n < nops; n++) begin
            check_op("random", 16'($urandom), 4'($urandom), 2'($urandom));
            if ($urandom_range(3) == 0) begin
                bus.start = 1'b0;
                tick();
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (done_seen != nops) begin
            errors++;
            $display("FAIL done_count: got %0d, required %0d", done_seen, nops);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_mid_shift();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
